// File: rtl/qpp_interleaver_stream_if.sv
// Handshake bundle for qpp_interleaver_stream: config, serial input and
// paired output channels. The master side drives offers and consumes results.
// The slave side is the interleaver itself.
interface qpp_interleaver_stream_if #(
   parameter int KW = 13
);
   // Configuration channel.
   logic          cfg_valid;
   logic          cfg_ready;
   logic [KW-1:0] cfg_k;
   logic [KW-1:0] cfg_f1;
   logic [KW-1:0] cfg_f2;
   logic          cfg_err;

   // Serial input channel.
   logic          in_valid;
   logic          in_ready;
   logic          in_bit;

   // Paired output channel.
   logic          out_valid;
   logic          out_ready;
   logic          out_sys;
   logic          out_int;
   logic [KW-1:0] out_addr;
   logic          out_last;

   modport master (
      output cfg_valid, cfg_k, cfg_f1, cfg_f2, in_valid, in_bit, out_ready,
      input  cfg_ready, cfg_err, in_ready, out_valid, out_sys, out_int,
             out_addr, out_last
   );

   modport slave (
      input  cfg_valid, cfg_k, cfg_f1, cfg_f2, in_valid, in_bit, out_ready,
      output cfg_ready, cfg_err, in_ready, out_valid, out_sys, out_int,
             out_addr, out_last
   );
endinterface

// File: rtl/qpp_interleaver_stream.sv
// Streaming QPP turbo interleaver. It buffers one block of K serial bits and
// then emits (buffer[i], buffer[pi(i)]) in natural order, where
// pi(i) = (f1*i + f2*i^2) mod K. pi is generated recursively with
// first and second differences. Each step is an add followed by one
// conditional subtract, so the design needs no multiplier.
module qpp_interleaver_stream #(
   parameter int KMAX = 6144,
   parameter int KW   = 13
) (
   input  logic                     clk,
   input  logic                     rst,
   qpp_interleaver_stream_if.slave  bus
);

   localparam int            AW    = $clog2(KMAX);
   localparam logic [KW-1:0] K_MIN = KW'(40);
   localparam logic [KW-1:0] K_MAX = KW'(KMAX);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      READ
   } state_t;

   state_t        state;
   state_t        state_next;

   logic [KW-1:0] k_r;
   logic [KW-1:0] f1_r;
   logic [KW-1:0] f2_r;
   logic [KW-1:0] wr_idx;
   logic [KW-1:0] rd_i;
   logic [KW-1:0] pi_r;
   logic [KW-1:0] g_r;
   logic [KW-1:0] d_r;
   logic          cfg_err_r;

   logic          mem [KMAX];

   logic          cfg_ok;
   logic          cfg_fire;
   logic          in_fire;
   logic          out_fire;
   logic          in_last;
   logic          rd_last;

   // (a + b) mod m for a, b < m. The sum is one bit wider, so it cannot
   // overflow, and a single conditional subtract completes the reduction.
   function automatic logic [KW-1:0] mod_add(input logic [KW-1:0] a,
                                             input logic [KW-1:0] b,
                                             input logic [KW-1:0] m);
      logic [KW:0] s;
      // NOTE: blocking '=' belongs in functions and always_comb, where
      // values must be visible at once; state registers use '<=' only.
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) begin
         s = s - {1'b0, m};
      end
      return s[KW-1:0];
   endfunction

   assign cfg_ok = (bus.cfg_k >= K_MIN) && (bus.cfg_k <= K_MAX) &&
                   (bus.cfg_k[2:0] == 3'd0) &&
                   (bus.cfg_f1 < bus.cfg_k) && (bus.cfg_f2 < bus.cfg_k);

   // The ready and valid signals are pure state decodes, so each fire
   // term is the state qualifier ANDed with the partner's strobe.
   assign cfg_fire = (state == IDLE) && bus.cfg_valid;
   assign in_fire  = (state == LOAD) && bus.in_valid;
   assign out_fire = (state == READ) && bus.out_ready;
   assign in_last  = (wr_idx == k_r - KW'(1));
   assign rd_last  = (rd_i == k_r - KW'(1));

   assign bus.cfg_err = cfg_err_r;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and handshake/output drive.
   always_comb begin
      // NOTE: every output of this block gets a default first. Otherwise a
      // path that skips an assignment would infer a latch.
      state_next    = state;
      bus.cfg_ready = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_sys   = 1'b0;
      bus.out_int   = 1'b0;
      bus.out_addr  = '0;
      bus.out_last  = 1'b0;
      unique case (state)
         IDLE: begin
            bus.cfg_ready = 1'b1;
            if (bus.cfg_valid && cfg_ok) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid && in_last) begin
               state_next = READ;
            end
         end
         READ: begin
            bus.out_valid = 1'b1;
            bus.out_sys   = mem[rd_i[AW-1:0]];
            bus.out_int   = mem[pi_r[AW-1:0]];
            bus.out_addr  = pi_r;
            bus.out_last  = rd_last;
            if (bus.out_ready && rd_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Block parameters, write index and recursive address generator.
   always_ff @(posedge clk) begin
      if (rst) begin
         k_r       <= '0;
         f1_r      <= '0;
         f2_r      <= '0;
         wr_idx    <= '0;
         rd_i      <= '0;
         pi_r      <= '0;
         g_r       <= '0;
         d_r       <= '0;
         cfg_err_r <= 1'b0;
      end else begin
         cfg_err_r <= cfg_fire && !cfg_ok;

         if (cfg_fire && cfg_ok) begin
            k_r    <= bus.cfg_k;
            f1_r   <= bus.cfg_f1;
            f2_r   <= bus.cfg_f2;
            wr_idx <= '0;
         end

         if (in_fire) begin
            wr_idx <= wr_idx + KW'(1);
            if (in_last) begin
               // pi(0) = 0. The first difference is g(0) = f1 + f2, and
               // the second difference is constant at 2*f2.
               rd_i <= '0;
               pi_r <= '0;
               g_r  <= mod_add(f1_r, f2_r, k_r);
               d_r  <= mod_add(f2_r, f2_r, k_r);
            end
         end

         if (out_fire) begin
            rd_i <= rd_i + KW'(1);
            pi_r <= mod_add(pi_r, g_r, k_r);
            g_r  <= mod_add(g_r, d_r, k_r);
         end
      end
   end

   // Block buffer write port.
   always_ff @(posedge clk) begin
      // NOTE: the buffer is deliberately not reset. Every location read in a
      // block is written in the same block first, so clearing it would only
      // cost logic.
      if (in_fire) begin
         mem[wr_idx[AW-1:0]] <= bus.in_bit;
      end
   end

endmodule

// File: tb/tb_qpp_interleaver_stream.sv
// Scoreboard bench for qpp_interleaver_stream. The stimulus pushes the
// expected pairs, built from the closed-form QPP expression, into a queue
// before each block loads. A negedge monitor pops that queue and compares on
// every output handshake. The monitor also checks hold stability and
// address uniqueness.
module tb_qpp_interleaver_stream;

   localparam int KMAX = 6144;
   localparam int KW   = 13;

   typedef struct {
      int i;
      int addr;
      bit sys;
      bit intl;
      bit last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   qpp_interleaver_stream_if #(.KW(KW)) bus ();

   qpp_interleaver_stream #(.KMAX(KMAX), .KW(KW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   bit   data_buf [KMAX];
   bit   seen [8192];
   bit   bp_mode = 1'b0;

   int   obs_addr[$];
   int   obs_sys[$];
   int   obs_int[$];
   int   obs_last[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Downstream ready: always accept, or accept randomly at 50 % in bp_mode.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: hold-stability check, then scoreboard pop on each handshake.
   initial begin
      exp_t e;
      bit   stall_prev = 1'b0;
      logic [KW-1:0] h_addr;
      logic h_sys, h_int, h_last;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("hold_valid", bus.out_valid, 1);
               check("hold_addr", bus.out_addr, h_addr);
               check("hold_sys", bus.out_sys, h_sys);
               check("hold_int", bus.out_int, h_int);
               check("hold_last", bus.out_last, h_last);
            end
            if (bus.out_valid && bus.out_ready) begin
               check("unexpected_output", (exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  if (e.i == 0) begin
                     for (int j = 0; j < 8192; j++) seen[j] = 1'b0;
                  end
                  check("out_addr", bus.out_addr, e.addr);
                  check("out_sys", bus.out_sys, e.sys);
                  check("out_int", bus.out_int, e.intl);
                  check("out_last", bus.out_last, e.last);
                  check("addr_unique", seen[bus.out_addr], 0);
                  seen[bus.out_addr] = 1'b1;
               end
               obs_addr.push_back(int'(bus.out_addr));
               obs_sys.push_back(int'(bus.out_sys));
               obs_int.push_back(int'(bus.out_int));
               obs_last.push_back(int'(bus.out_last));
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            h_addr = bus.out_addr;
            h_sys  = bus.out_sys;
            h_int  = bus.out_int;
            h_last = bus.out_last;
         end
      end
   end

   // Global time limit so that a stuck DUT cannot hang the run.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic clear_logs();
      obs_addr.delete();
      obs_sys.delete();
      obs_int.delete();
      obs_last.delete();
   endtask

   task automatic send_cfg(input int k, input int f1, input int f2);
      check("cfg_ready_before_cfg", bus.cfg_ready, 1);
      bus.cfg_valid = 1'b1;
      bus.cfg_k     = KW'(k);
      bus.cfg_f1    = KW'(f1);
      bus.cfg_f2    = KW'(f2);
      tick();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic push_model(input int k, input int f1, input int f2);
      exp_t   e;
      longint a;
      for (int i = 0; i < k; i++) begin
         a      = (longint'(f1) * i + longint'(f2) * i * i) % k;
         e.i    = i;
         e.addr = int'(a);
         e.sys  = data_buf[i];
         e.intl = data_buf[int'(a)];
         e.last = (i == k - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic load_bits(input int k, input bit gaps);
      for (int i = 0; i < k; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               bus.in_valid = 1'b0;
               tick();
            end
         end
         bus.in_valid = 1'b1;
         bus.in_bit   = data_buf[i];
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic start_block(input int k, input int f1, input int f2,
                              input bit gaps);
      send_cfg(k, f1, f2);
      check("in_ready_after_cfg", bus.in_ready, 1);
      push_model(k, f1, f2);
      load_bits(k, gaps);
      check("first_out_valid", bus.out_valid, 1);
      check("first_out_addr", bus.out_addr, 0);
   endtask

   task automatic finish_block(input int budget);
      int n = 0;
      while (!bus.cfg_ready && n < budget) begin
         tick();
         n++;
      end
      check("block_idle_timeout", bus.cfg_ready, 1);
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic fill_random(input int k);
      for (int i = 0; i < k; i++) data_buf[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic find_ones(input int q[$], output int cnt, output int pos);
      cnt = 0;
      pos = -1;
      foreach (q[j]) begin
         if (q[j] != 0) begin
            cnt++;
            pos = j;
         end
      end
   endtask

   initial begin
      int t1_addr[5] = '{0, 13, 6, 19, 12};
      int ref_addr[$];
      int ref_sys[$];
      int ref_int[$];
      int cnt;
      int pos;
      int n;

      rst           = 1'b1;
      bus.cfg_valid = 1'b0;
      bus.cfg_k     = '0;
      bus.cfg_f1    = '0;
      bus.cfg_f2    = '0;
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      repeat (3) tick();

      // Reset values.
      check("rst_cfg_ready", bus.cfg_ready, 1);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_cfg_err", bus.cfg_err, 0);
      check("rst_out_sys", bus.out_sys, 0);
      check("rst_out_int", bus.out_int, 0);
      check("rst_out_addr", bus.out_addr, 0);
      rst = 1'b0;
      tick();

      // Small block with one set bit at position 13.
      for (int i = 0; i < KMAX; i++) data_buf[i] = 1'b0;
      data_buf[13] = 1'b1;
      clear_logs();
      start_block(40, 3, 10, 1'b0);
      finish_block(200);
      check("t1_count", obs_addr.size(), 40);
      for (int j = 0; j < 5; j++) begin
         if (j < obs_addr.size()) check("t1_addr_seq", obs_addr[j], t1_addr[j]);
      end
      find_ones(obs_int, cnt, pos);
      check("t1_int_ones", cnt, 1);
      check("t1_int_pos", pos, 1);
      find_ones(obs_sys, cnt, pos);
      check("t1_sys_ones", cnt, 1);
      check("t1_sys_pos", pos, 13);
      find_ones(obs_last, cnt, pos);
      check("t1_last_ones", cnt, 1);
      check("t1_last_pos", pos, 39);

      // Full-size block with random data.
      fill_random(6144);
      clear_logs();
      start_block(6144, 263, 480, 1'b0);
      finish_block(7000);
      check("t2_count", obs_addr.size(), 6144);

      // Config rejection: bad K mod 8, K above KMAX, f1 not below K.
      send_cfg(44, 3, 10);
      check("rej44_err", bus.cfg_err, 1);
      check("rej44_in_ready", bus.in_ready, 0);
      tick();
      check("rej44_err_clear", bus.cfg_err, 0);
      send_cfg(8000, 3, 10);
      check("rej8000_err", bus.cfg_err, 1);
      check("rej8000_in_ready", bus.in_ready, 0);
      tick();
      check("rej8000_err_clear", bus.cfg_err, 0);
      send_cfg(40, 40, 10);
      check("rejf1_err", bus.cfg_err, 1);
      check("rejf1_in_ready", bus.in_ready, 0);
      tick();
      check("rejf1_err_clear", bus.cfg_err, 0);
      check("rej_in_ready_idle", bus.in_ready, 0);
      fill_random(48);
      start_block(48, 7, 12, 1'b0);
      check("accept48_cfg_err", bus.cfg_err, 0);
      finish_block(200);

      // Backpressure: the reference run first, then the same data with stalls.
      fill_random(40);
      clear_logs();
      start_block(40, 3, 10, 1'b0);
      finish_block(200);
      ref_addr = obs_addr;
      ref_sys  = obs_sys;
      ref_int  = obs_int;
      clear_logs();
      bp_mode = 1'b1;
      start_block(40, 3, 10, 1'b1);
      finish_block(2000);
      bp_mode = 1'b0;
      tick();
      check("bp_count", obs_addr.size(), ref_addr.size());
      for (int j = 0; j < ref_addr.size(); j++) begin
         if (j < obs_addr.size()) begin
            check("bp_addr_same", obs_addr[j], ref_addr[j]);
            check("bp_sys_same", obs_sys[j], ref_sys[j]);
            check("bp_int_same", obs_int[j], ref_int[j]);
         end
      end

      // Reset after 20 bits of a K=40 block.
      fill_random(40);
      send_cfg(40, 3, 10);
      load_bits(20, 1'b0);
      rst = 1'b1;
      tick();
      check("mid_rst_cfg_ready", bus.cfg_ready, 1);
      check("mid_rst_in_ready", bus.in_ready, 0);
      check("mid_rst_out_valid", bus.out_valid, 0);
      rst = 1'b0;
      tick();
      fill_random(40);
      start_block(40, 3, 10, 1'b0);
      finish_block(200);

      // Back-to-back: the next config goes in on the cycle after out_last fires.
      fill_random(40);
      start_block(40, 3, 10, 1'b0);
      n = 0;
      while (!(bus.out_valid && bus.out_ready && bus.out_last) && n < 200) begin
         tick();
         n++;
      end
      check("b2b_last_timeout", bus.out_last, 1);
      tick();
      check("b2b_cfg_ready", bus.cfg_ready, 1);
      fill_random(2560);
      start_block(2560, 39, 80, 1'b0);
      finish_block(3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
